// File: rtl/sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl
// Per-frame motion scheduler for the player sprite. Every DIV frame_clk
// cycles one physics step is taken: horizontal walk is applied in every
// state, and the vertical state machine (GROUND/RISE/APEX/FALL) moves the
// sprite and resolves collisions. The colliders are the floor, one fixed
// platform (top surface and underside) and the screen edges.
//
// Ports
//   frame_clk  in   1   frame clock
//   Reset      in   1   asynchronous, active-high reset
//   keycode    in  16   bit0 jump, bit2 left, bit3 right; other bits ignored
//   pos_x      out 10   sprite x (registered)
//   pos_y      out 10   sprite y (registered)
//   on_gnd     out  1   high while the sprite is in GROUND (registered)
//   state_dbg  out  2   GROUND=0, RISE=1, APEX=2, FALL=3 (registered)
// ---------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int unsigned DIV        = 3,
  parameter logic [9:0]  START_X    = 10'd100,
  parameter logic [9:0]  START_Y    = 10'd368,
  parameter logic [9:0]  GROUND_Y   = 10'd368,
  parameter logic [9:0]  X_MIN      = 10'd0,
  parameter logic [9:0]  X_MAX      = 10'd619,
  parameter logic [9:0]  PLAT_X0    = 10'd296,
  parameter logic [9:0]  PLAT_X1    = 10'd345,
  parameter logic [9:0]  PLAT_Y     = 10'd331,
  parameter logic [9:0]  PLAT_T     = 10'd32,
  parameter logic [9:0]  JUMP_V     = 10'd6,
  parameter logic [9:0]  WALK_V     = 10'd2,
  parameter int unsigned RISE_STEPS = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        on_gnd,
  output logic [1:0]  state_dbg
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RC_W  = $clog2(RISE_STEPS + 1);
  localparam int unsigned PW    = 11;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(RISE_STEPS);
  localparam logic [PW-1:0]    PLAT_UNDER = PW'(PLAT_Y) + PW'(PLAT_T);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_APEX   = 2'd2,
    ST_FALL   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [9:0]        r_pos_x;
  logic [9:0]        r_pos_y;
  logic [RC_W-1:0]   r_rise_cnt;
  logic              r_jump_armed;
  logic              r_on_gnd;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [9:0]        w_x_nxt;
  logic [9:0]        w_y_nxt;
  logic [RC_W-1:0]   w_rc_nxt;
  logic              w_armed_nxt;

  logic              w_step;
  logic              w_key_jump;
  logic              w_key_left;
  logic              w_key_right;
  logic              w_fire;
  logic              w_inplat;
  logic              w_supported;
  logic [PW-1:0]     w_x11;
  logic [PW-1:0]     w_y11;
  logic [PW-1:0]     w_x_left;
  logic [PW-1:0]     w_x_sum;
  logic [PW-1:0]     w_x_right;
  logic [PW-1:0]     w_ny_up;
  logic              w_ny_neg;
  logic [PW-1:0]     w_ny_dn;
  logic [RC_W-1:0]   w_rc_inc;
  logic              w_unused_keys;

  // Keycode decode; only jump/left/right matter.
  assign w_key_jump    = keycode[0];
  assign w_key_left    = keycode[2];
  assign w_key_right   = keycode[3];
  assign w_unused_keys = ^{keycode[15:4], keycode[1]};

  // Physics step strobe: last cycle of each DIV-cycle window.
  assign w_step    = (r_cnt == CNT_LAST);
  assign w_cnt_nxt = w_step ? '0 : r_cnt + CNT_W'(1);

  // Collision context, always taken from the pre-step position.
  assign w_inplat    = (r_pos_x >= PLAT_X0) && (r_pos_x <= PLAT_X1);
  assign w_supported = (r_pos_y == GROUND_Y) || ((r_pos_y == PLAT_Y) && w_inplat);
  assign w_fire      = r_jump_armed && w_key_jump;

  // Horizontal candidates at 11 bits so neither edge can wrap.
  assign w_x11     = {1'b0, r_pos_x};
  assign w_x_left  = (w_x11 >= (PW'(X_MIN) + PW'(WALK_V))) ? (w_x11 - PW'(WALK_V)) : PW'(X_MIN);
  assign w_x_sum   = w_x11 + PW'(WALK_V);
  assign w_x_right = (w_x_sum > PW'(X_MAX)) ? PW'(X_MAX) : w_x_sum;

  // Vertical candidates; w_ny_neg marks a rise that would go above row 0.
  assign w_y11    = {1'b0, r_pos_y};
  assign w_ny_up  = w_y11 - PW'(JUMP_V);
  assign w_ny_neg = (w_y11 < PW'(JUMP_V));
  assign w_ny_dn  = w_y11 + PW'(JUMP_V);
  assign w_rc_inc = r_rise_cnt + RC_W'(1);

  // State register and datapath registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_GROUND;
      r_cnt        <= '0;
      r_pos_x      <= START_X;
      r_pos_y      <= START_Y;
      r_rise_cnt   <= '0;
      r_jump_armed <= 1'b0;
      r_on_gnd     <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pos_x      <= w_x_nxt;
      r_pos_y      <= w_y_nxt;
      r_rise_cnt   <= w_rc_nxt;
      r_jump_armed <= w_armed_nxt;
      r_on_gnd     <= (w_state_nxt == ST_GROUND);
    end
  end

  // Next-state and next-position logic; everything holds between steps.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_pos_x;
    w_y_nxt     = r_pos_y;
    w_rc_nxt    = r_rise_cnt;
    w_armed_nxt = r_jump_armed;

    if (w_step) begin
      // Re-arm only after jump is released, so a held key never repeats.
      w_armed_nxt = ~w_key_jump;

      if (w_key_left && !w_key_right) begin
        w_x_nxt = 10'(w_x_left);
      end else if (w_key_right && !w_key_left) begin
        w_x_nxt = 10'(w_x_right);
      end

      unique case (r_state)
        ST_GROUND: begin
          if (!w_supported) begin
            w_state_nxt = ST_FALL;
          end else if (w_fire) begin
            w_state_nxt = ST_RISE;
            w_rc_nxt    = '0;
          end
        end

        ST_RISE: begin
          // Head bump: crossing the platform underside from below.
          if (w_inplat && (w_y11 >= PLAT_UNDER) && (w_ny_neg || (w_ny_up < PLAT_UNDER))) begin
            w_y_nxt     = 10'(PLAT_UNDER);
            w_state_nxt = ST_FALL;
          end else if (w_ny_neg) begin
            w_y_nxt     = '0;
            w_state_nxt = ST_FALL;
          end else begin
            w_y_nxt  = 10'(w_ny_up);
            w_rc_nxt = w_rc_inc;
            if (w_rc_inc == RC_LAST) begin
              w_state_nxt = ST_APEX;
            end
          end
        end

        ST_APEX: begin
          w_state_nxt = ST_FALL;
        end

        ST_FALL: begin
          // Platform top wins over the floor when both would be crossed.
          if (w_inplat && (w_y11 <= PW'(PLAT_Y)) && (w_ny_dn >= PW'(PLAT_Y))) begin
            w_y_nxt     = PLAT_Y;
            w_state_nxt = ST_GROUND;
          end else if (w_ny_dn >= PW'(GROUND_Y)) begin
            w_y_nxt     = GROUND_Y;
            w_state_nxt = ST_GROUND;
          end else begin
            w_y_nxt = 10'(w_ny_dn);
          end
        end
      endcase
    end
  end

  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign on_gnd    = r_on_gnd;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Five instances with different start positions run in lockstep, each with
// its own keycode. A step-level behavioural model tracks every instance;
// directed tables and sequences cover jump arc, head bump, platform landing,
// walk-off, edge clamps, held-jump behaviour and reset mid-jump, followed by
// randomized keycodes.
// ---------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

  localparam int NI     = 5;
  localparam int GY     = 368;
  localparam int PY     = 331;
  localparam int PUNDER = 363;
  localparam int PX0    = 296;
  localparam int PX1    = 345;
  localparam int XMAX   = 619;
  localparam int JV     = 6;
  localparam int WV     = 2;
  localparam int RSTEPS = 3;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] kc [NI];
  logic [9:0]  px [NI];
  logic [9:0]  py [NI];
  logic        og [NI];
  logic [1:0]  sd [NI];

  always #5 frame_clk = ~frame_clk;

  sprite_motion_ctrl u_a (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(kc[0]),
    .pos_x(px[0]), .pos_y(py[0]), .on_gnd(og[0]), .state_dbg(sd[0]));
  sprite_motion_ctrl #(.START_X(10'd300), .START_Y(10'd368)) u_b (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(kc[1]),
    .pos_x(px[1]), .pos_y(py[1]), .on_gnd(og[1]), .state_dbg(sd[1]));
  sprite_motion_ctrl #(.START_X(10'd300), .START_Y(10'd320)) u_c (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(kc[2]),
    .pos_x(px[2]), .pos_y(py[2]), .on_gnd(og[2]), .state_dbg(sd[2]));
  sprite_motion_ctrl #(.START_X(10'd345), .START_Y(10'd331)) u_d (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(kc[3]),
    .pos_x(px[3]), .pos_y(py[3]), .on_gnd(og[3]), .state_dbg(sd[3]));
  sprite_motion_ctrl #(.START_X(10'd1), .START_Y(10'd368)) u_e (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(kc[4]),
    .pos_x(px[4]), .pos_y(py[4]), .on_gnd(og[4]), .state_dbg(sd[4]));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int x;
    int y;
    int st;
    int rc;
    bit armed;
  } mdl_t;

  mdl_t m [NI];
  int   sx [NI] = '{100, 300, 300, 345, 1};
  int   sy [NI] = '{368, 368, 320, 331, 368};

  typedef struct {
    logic [15:0] key;
    int a_y;
    int a_st;
    int b_y;
    int b_st;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic mdl_t mreset(input int i);
    mdl_t r;
    r.x = sx[i]; r.y = sy[i]; r.st = 0; r.rc = 0; r.armed = 1'b0;
    return r;
  endfunction

  // One physics step from the rules: walk, then the vertical mode.
  function automatic mdl_t mstep(input mdl_t c, input logic [15:0] k);
    mdl_t n;
    int   ny;
    bit   inplat, sup, jj, jl, jr;
    n  = c;
    jj = k[0]; jl = k[2]; jr = k[3];
    inplat = (c.x >= PX0) && (c.x <= PX1);
    sup    = (c.y == GY) || ((c.y == PY) && inplat);
    if (jl && !jr)      n.x = (c.x - WV < 0) ? 0 : c.x - WV;
    else if (jr && !jl) n.x = (c.x + WV > XMAX) ? XMAX : c.x + WV;
    n.armed = !jj;
    case (c.st)
      0: begin
        if (!sup) n.st = 3;
        else if (c.armed && jj) begin n.st = 1; n.rc = 0; end
      end
      1: begin
        ny = c.y - JV;
        if (inplat && c.y >= PUNDER && ny < PUNDER) begin n.y = PUNDER; n.st = 3; end
        else if (ny < 0) begin n.y = 0; n.st = 3; end
        else begin
          n.y  = ny;
          n.rc = c.rc + 1;
          if (n.rc == RSTEPS) n.st = 2;
        end
      end
      2: n.st = 3;
      default: begin
        ny = c.y + JV;
        if (inplat && c.y <= PY && ny >= PY) begin n.y = PY; n.st = 0; end
        else if (ny >= GY) begin n.y = GY; n.st = 0; end
        else n.y = ny;
      end
    endcase
    return n;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.x[%0d]", tag, i), 32'(px[i]), 32'(m[i].x));
      chk($sformatf("%s.y[%0d]", tag, i), 32'(py[i]), 32'(m[i].y));
      chk($sformatf("%s.st[%0d]", tag, i), 32'(sd[i]), 32'(m[i].st));
      chk($sformatf("%s.gnd[%0d]", tag, i), 32'(og[i]), 32'(m[i].st == 0));
    end
  endtask

  // One physics window: outputs must hold mid-window, then update once.
  task automatic do_step();
    @(posedge frame_clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("hold.x[%0d]", i), 32'(px[i]), 32'(m[i].x));
      chk($sformatf("hold.y[%0d]", i), 32'(py[i]), 32'(m[i].y));
    end
    @(posedge frame_clk);
    @(posedge frame_clk); #1;
    for (int i = 0; i < NI; i++) m[i] = mstep(m[i], kc[i]);
    check_all("step");
  endtask

  initial begin
    vec_t tbl [8];
    int   c_y  [3] = '{320, 326, 331};
    int   c_st [3] = '{3, 3, 0};
    int   d_y  [9] = '{331, 331, 337, 343, 349, 355, 361, 367, 368};
    int   d_st [9] = '{0, 3, 3, 3, 3, 3, 3, 3, 0};
    int   n_rise;
    logic [1:0] prev;

    tbl[0] = '{16'h0001, 368, 1, 368, 1};
    tbl[1] = '{16'h0000, 362, 1, 363, 3};
    tbl[2] = '{16'h0000, 356, 1, 368, 0};
    tbl[3] = '{16'h0000, 350, 2, 368, 0};
    tbl[4] = '{16'h0000, 350, 3, 368, 0};
    tbl[5] = '{16'h0000, 356, 3, 368, 0};
    tbl[6] = '{16'h0000, 362, 3, 368, 0};
    tbl[7] = '{16'h0000, 368, 0, 368, 0};

    Reset = 1'b1;
    for (int i = 0; i < NI; i++) begin kc[i] = '0; m[i] = mreset(i); end
    #22;
    check_all("reset");
    chk("reset.a_x", 32'(px[0]), 32'd100);
    chk("reset.a_y", 32'(py[0]), 32'd368);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Idle 30 frames: A stays put, C drops onto the platform.
    for (int s = 0; s < 10; s++) begin
      do_step();
      chk("idle.a_x", 32'(px[0]), 32'd100);
      chk("idle.a_y", 32'(py[0]), 32'd368);
      chk("idle.a_st", 32'(sd[0]), 32'd0);
      if (s < 3) begin
        chk($sformatf("plat_land.y%0d", s), 32'(py[2]), 32'(c_y[s]));
        chk($sformatf("plat_land.st%0d", s), 32'(sd[2]), 32'(c_st[s]));
      end
    end
    chk("plat_land.gnd", 32'(og[2]), 32'd1);

    // Full jump arc on A and head bump on B.
    for (int r = 0; r < 8; r++) begin
      kc[0] = tbl[r].key;
      kc[1] = tbl[r].key;
      do_step();
      chk($sformatf("jump.y%0d", r), 32'(py[0]), 32'(tbl[r].a_y));
      chk($sformatf("jump.st%0d", r), 32'(sd[0]), 32'(tbl[r].a_st));
      chk($sformatf("jump.gnd%0d", r), 32'(og[0]), 32'(tbl[r].a_st == 0));
      chk($sformatf("jump.x%0d", r), 32'(px[0]), 32'd100);
      chk($sformatf("bump.y%0d", r), 32'(py[1]), 32'(tbl[r].b_y));
      chk($sformatf("bump.st%0d", r), 32'(sd[1]), 32'(tbl[r].b_st));
    end

    // Walk off the platform edge (D), left clamp (E), left+right hold (A).
    kc[0] = 16'h000C; kc[1] = '0; kc[2] = '0; kc[3] = 16'h0008; kc[4] = 16'h0004;
    for (int s = 0; s < 9; s++) begin
      do_step();
      chk($sformatf("walkoff.x%0d", s), 32'(px[3]), 32'(347 + 2 * s));
      chk($sformatf("walkoff.y%0d", s), 32'(py[3]), 32'(d_y[s]));
      chk($sformatf("walkoff.st%0d", s), 32'(sd[3]), 32'(d_st[s]));
      chk($sformatf("clamp_l.x%0d", s), 32'(px[4]), 32'd0);
      chk($sformatf("lr_hold.x%0d", s), 32'(px[0]), 32'd100);
    end

    // Held jump produces exactly one jump; release and press re-arms.
    for (int i = 0; i < NI; i++) kc[i] = '0;
    kc[0] = 16'h0001;
    n_rise = 0;
    prev = sd[0];
    for (int s = 0; s < 14; s++) begin
      do_step();
      if (sd[0] == 2'd1 && prev != 2'd1) n_rise++;
      prev = sd[0];
    end
    chk("held_jump.count", 32'(n_rise), 32'd1);
    chk("held_jump.st", 32'(sd[0]), 32'd0);
    chk("held_jump.y", 32'(py[0]), 32'd368);
    kc[0] = 16'h0000;
    do_step();
    chk("rearm.idle_st", 32'(sd[0]), 32'd0);
    kc[0] = 16'h0001;
    do_step();
    chk("rearm.st", 32'(sd[0]), 32'd1);
    kc[0] = 16'h0000;
    do_step();
    chk("rearm.rise_y", 32'(py[0]), 32'd362);

    // Asynchronous reset in the middle of RISE.
    @(negedge frame_clk); #1;
    Reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) m[i] = mreset(i);
    chk("midreset.x", 32'(px[0]), 32'd100);
    chk("midreset.y", 32'(py[0]), 32'd368);
    chk("midreset.st", 32'(sd[0]), 32'd0);
    chk("midreset.gnd", 32'(og[0]), 32'd1);
    check_all("midreset");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Randomized keycodes against the model.
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < NI; i++) kc[i] = 16'($urandom);
      do_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
